// File: rtl/icache_req_arb.sv
// -----------------------------------------------------------------------------
// icache_req_arb
//   Arbitrates the single i-cache read port between IFU demand fetches and the
//   next-line prefetcher. Only one cache read is outstanding at a time. Demand
//   wins by default. A prefetch that has lost PF_MAX_WAIT demand grants in a
//   row wins the next grant. A prefetch still in flight is handed to the IFU as
//   a demand completion when the pending demand targets the same line. A flush
//   drops the in-flight read: its response is drained and discarded.
//
//   Optional feature macro: ICARB_PERF_CNT_EN adds saturating performance
//   counters (cnt_dem_o, cnt_pf_o, cnt_promote_o).
//
// Ports
//   clk_i, rst_n_i          clock, asynchronous active-low reset
//   flush_i                 pipeline flush
//   dem_req_i/dem_addr_i    demand request (level) and fetch address
//   dem_done_o/dem_line_o   demand completion and returned line
//   pf_req_i/pf_addr_i      prefetch request (level) and address
//   pf_gnt_o                prefetch accepted by the cache (pulse)
//   pf_done_o               prefetch completed and not promoted
//   cache_req_o/_addr_o     read request to the i-cache
//   cache_ready_i           i-cache accepts the request
//   cache_done_i/_out_i     read response valid and payload
//   cnt_*_o                 performance counters (ICARB_PERF_CNT_EN only)
// -----------------------------------------------------------------------------
package icache_req_arb_pkg;
  localparam int XLEN          = 32;
  localparam int ICACHE_OFFSET = 6;
  localparam int LINE_W        = 64;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [LINE_W-1:0] line;
  } icache_out_t;
endpackage

module icache_req_arb
  import icache_req_arb_pkg::*;
#(
  parameter int PF_MAX_WAIT = 8,
  parameter int CNT_W       = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              flush_i,
  input  logic              dem_req_i,
  input  logic [XLEN-1:0]   dem_addr_i,
  output logic              dem_done_o,
  output icache_out_t       dem_line_o,
  input  logic              pf_req_i,
  input  logic [XLEN-1:0]   pf_addr_i,
  output logic              pf_gnt_o,
  output logic              pf_done_o,
  output logic              cache_req_o,
  output logic [XLEN-1:0]   cache_addr_o,
  input  logic              cache_ready_i,
  input  logic              cache_done_i,
  input  icache_out_t       cache_out_i
`ifdef ICARB_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  cnt_dem_o,
  output logic [CNT_W-1:0]  cnt_pf_o,
  output logic [CNT_W-1:0]  cnt_promote_o
`endif
);

  localparam int TAG_W  = XLEN - ICACHE_OFFSET;
  localparam int WAIT_W = $clog2(PF_MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(PF_MAX_WAIT);

  if (PF_MAX_WAIT < 1 || CNT_W < 1) begin : g_param_chk
    $error("icache_req_arb: PF_MAX_WAIT and CNT_W must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, BUSY_DEM, BUSY_PF, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q;
  logic [TAG_W-1:0]    tag_q;
  logic                sel_pf;
  logic                issue;
  logic                promote;

  always_comb begin
    state_d      = state_q;
    cache_req_o  = 1'b0;
    cache_addr_o = '0;
    pf_gnt_o     = 1'b0;
    dem_done_o   = 1'b0;
    pf_done_o    = 1'b0;
    sel_pf       = 1'b0;
    issue        = 1'b0;
    promote      = 1'b0;
    case (state_q)
      IDLE: begin
        // A lone prefetch is always taken; against a demand it needs a full
        // run of lost grants first.
        sel_pf      = pf_req_i & (~dem_req_i | (wait_cnt_q == WAIT_MAX));
        cache_req_o = (dem_req_i | pf_req_i) & ~flush_i;
        if (cache_req_o) cache_addr_o = sel_pf ? pf_addr_i : dem_addr_i;
        issue    = cache_req_o & cache_ready_i;
        pf_gnt_o = issue & sel_pf;
        if (issue) state_d = sel_pf ? BUSY_PF : BUSY_DEM;
      end
      BUSY_DEM: begin
        if (cache_done_i) begin
          dem_done_o = ~flush_i;
          state_d    = IDLE;
        end else if (flush_i) begin
          state_d = DRAIN;
        end
      end
      BUSY_PF: begin
        // The prefetched line serves a waiting demand for the same line.
        promote = dem_req_i & (dem_addr_i[XLEN-1:ICACHE_OFFSET] == tag_q);
        if (cache_done_i) begin
          dem_done_o = ~flush_i & promote;
          pf_done_o  = ~flush_i & ~promote;
          state_d    = IDLE;
        end else if (flush_i) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (cache_done_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign dem_line_o = dem_done_o ? cache_out_i : '0;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      tag_q      <= '0;
    end else begin
      state_q <= state_d;
      if (issue) tag_q <= cache_addr_o[XLEN-1:ICACHE_OFFSET];
      // Counts demand grants taken while a prefetch is waiting.
      if (flush_i || pf_gnt_o || !pf_req_i) begin
        wait_cnt_q <= '0;
      end else if (issue && !sel_pf && wait_cnt_q < WAIT_MAX) begin
        wait_cnt_q <= wait_cnt_q + 1'b1;
      end
    end
  end

`ifdef ICARB_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic pf_cmpl;
  logic prom_cmpl;

  assign prom_cmpl = dem_done_o & (state_q == BUSY_PF);
  assign pf_cmpl   = pf_done_o | prom_cmpl;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_dem_o     <= '0;
      cnt_pf_o      <= '0;
      cnt_promote_o <= '0;
    end else begin
      if (dem_done_o && cnt_dem_o != CNT_MAX)     cnt_dem_o     <= cnt_dem_o + 1'b1;
      if (pf_cmpl && cnt_pf_o != CNT_MAX)         cnt_pf_o      <= cnt_pf_o + 1'b1;
      if (prom_cmpl && cnt_promote_o != CNT_MAX)  cnt_promote_o <= cnt_promote_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_req_arb.sv
// -----------------------------------------------------------------------------
// tb_icache_req_arb
//   Self-checking bench for icache_req_arb. A transaction-level model (one
//   outstanding read record, a lost-grant count and a small cache responder)
//   predicts every output each cycle. Directed sequences cover the main usage
//   scenarios; a randomized phase mixes requests, flushes and back-pressure.
//   Perf-counter checks are compiled when ICARB_PERF_CNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_icache_req_arb;
  import icache_req_arb_pkg::*;

  localparam int PFW = 2;
  localparam int CW  = 16;

  logic            clk = 1'b0;
  logic            rst_n_i = 1'b0;
  logic            flush_i = 1'b0;
  logic            dem_req_i = 1'b0;
  logic [XLEN-1:0] dem_addr_i = '0;
  logic            dem_done_o;
  icache_out_t     dem_line_o;
  logic            pf_req_i = 1'b0;
  logic [XLEN-1:0] pf_addr_i = '0;
  logic            pf_gnt_o;
  logic            pf_done_o;
  logic            cache_req_o;
  logic [XLEN-1:0] cache_addr_o;
  logic            cache_ready_i = 1'b0;
  logic            cache_done_i = 1'b0;
  icache_out_t     cache_out_i = '0;
`ifdef ICARB_PERF_CNT_EN
  logic [CW-1:0]   cnt_dem_o, cnt_pf_o, cnt_promote_o;
`endif

  always #5 clk = ~clk;

  icache_req_arb #(.PF_MAX_WAIT(PFW), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .flush_i(flush_i),
    .dem_req_i(dem_req_i), .dem_addr_i(dem_addr_i),
    .dem_done_o(dem_done_o), .dem_line_o(dem_line_o),
    .pf_req_i(pf_req_i), .pf_addr_i(pf_addr_i),
    .pf_gnt_o(pf_gnt_o), .pf_done_o(pf_done_o),
    .cache_req_o(cache_req_o), .cache_addr_o(cache_addr_o),
    .cache_ready_i(cache_ready_i), .cache_done_i(cache_done_i),
    .cache_out_i(cache_out_i)
`ifdef ICARB_PERF_CNT_EN
    , .cnt_dem_o(cnt_dem_o), .cnt_pf_o(cnt_pf_o), .cnt_promote_o(cnt_promote_o)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Model: outstanding read record, prefetch lost-grant count, responder.
  bit                        m_busy, m_pf, m_drop;
  logic [XLEN-ICACHE_OFFSET-1:0] m_tag;
  int                        m_loss;
  bit                        e_pend;
  logic [XLEN-1:0]           e_addr;
  int                        e_cd;
  int                        lat_fix = -1;
  bit                        dem_active, pf_active;
  int                        n_dem_done, n_pf_done, n_issue;
  logic [XLEN-1:0]           last_pc;
  bit                        gnt_log[$];

  function automatic logic [XLEN-ICACHE_OFFSET-1:0] tag_of(input logic [XLEN-1:0] a);
    return a[XLEN-1:ICACHE_OFFSET];
  endfunction

  function automatic logic [XLEN-1:0] pick_addr();
    logic [XLEN-1:0] a;
    case ($urandom % 4)
      0: a = 32'h100;
      1: a = 32'h140;
      2: a = 32'h200;
      default: a = 32'h240;
    endcase
    return a | XLEN'(($urandom % 16) << 2);
  endfunction

  task automatic model_clear();
    m_busy = 0; m_pf = 0; m_drop = 0; m_tag = '0; m_loss = 0;
    e_pend = 0; e_cd = 0; dem_active = 0; pf_active = 0;
  endtask

  task automatic clr_obs();
    n_dem_done = 0; n_pf_done = 0; n_issue = 0; last_pc = '0;
    gnt_log.delete();
  endtask

  // One clock: entered and left at a falling edge.
  task automatic cycle();
    logic            x_req, x_pf, x_hs, x_gnt, x_dd, x_pd;
    logic [XLEN-1:0] x_addr;
    icache_out_t     x_line;
    dem_req_i = dem_active;
    pf_req_i  = pf_active;
    cache_done_i = e_pend && (e_cd == 0);
    cache_out_i.pc   = cache_done_i ? e_addr : XLEN'($urandom);
    cache_out_i.line = {$urandom, $urandom};
    #1;
    x_req = 0; x_pf = 0; x_hs = 0; x_gnt = 0; x_dd = 0; x_pd = 0; x_addr = '0;
    if (!m_busy) begin
      x_req = (dem_req_i || pf_req_i) && !flush_i;
      x_pf  = pf_req_i && (!dem_req_i || m_loss == PFW);
      if (x_req) x_addr = x_pf ? pf_addr_i : dem_addr_i;
      x_hs  = x_req && cache_ready_i;
      x_gnt = x_hs && x_pf;
    end else if (cache_done_i && !m_drop && !flush_i) begin
      if (!m_pf || (dem_req_i && tag_of(dem_addr_i) == m_tag)) x_dd = 1;
      else x_pd = 1;
    end
    x_line = x_dd ? cache_out_i : '0;
    check_eq("cache_req", cache_req_o, x_req);
    check_eq("cache_addr", cache_addr_o, x_addr);
    check_eq("pf_gnt", pf_gnt_o, x_gnt);
    check_eq("dem_done", dem_done_o, x_dd);
    check_eq("pf_done", pf_done_o, x_pd);
    check_eq("dem_line", dem_line_o, x_line);
    if (dem_done_o) begin n_dem_done++; last_pc = dem_line_o.pc; end
    if (pf_done_o) n_pf_done++;
    if (cache_req_o && cache_ready_i) begin n_issue++; gnt_log.push_back(pf_gnt_o); end
    // responder
    if (cache_done_i) e_pend = 0;
    else if (e_pend && e_cd > 0) e_cd--;
    // outstanding read
    if (!m_busy) begin
      if (x_hs) begin
        m_busy = 1; m_pf = x_pf; m_drop = 0; m_tag = tag_of(x_addr);
        e_pend = 1; e_addr = x_addr;
        e_cd = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
      end
    end else if (cache_done_i) m_busy = 0;
    else if (flush_i) m_drop = 1;
    if (flush_i || !pf_req_i || x_gnt) m_loss = 0;
    else if (x_hs && !x_pf && m_loss < PFW) m_loss++;
    if (x_dd) dem_active = 0;
    if (x_gnt) pf_active = 0;
    if (flush_i) begin dem_active = 0; pf_active = 0; end
    @(negedge clk);
  endtask

  task automatic run_until_done(input string tag);
    bit open;
    flush_i = 0; cache_ready_i = 1;
    for (int i = 0; i < 40 && (dem_active || pf_active || m_busy); i++) cycle();
    open = dem_active || pf_active || m_busy;
    check_eq({tag, "_timeout"}, open, 1'b0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_cache_req"}, cache_req_o, 1'b0);
    check_eq({tag, "_cache_addr"}, cache_addr_o, '0);
    check_eq({tag, "_pf_gnt"}, pf_gnt_o, 1'b0);
    check_eq({tag, "_dem_done"}, dem_done_o, 1'b0);
    check_eq({tag, "_pf_done"}, pf_done_o, 1'b0);
    check_eq({tag, "_dem_line"}, dem_line_o, '0);
`ifdef ICARB_PERF_CNT_EN
    check_eq({tag, "_cnt_dem"}, cnt_dem_o, '0);
    check_eq({tag, "_cnt_pf"}, cnt_pf_o, '0);
    check_eq({tag, "_cnt_promote"}, cnt_promote_o, '0);
`endif
  endtask

  initial begin
    model_clear();
    clr_obs();
    // reset state
    repeat (2) @(negedge clk);
    #1 check_outputs_zero("reset");
    @(negedge clk);
    rst_n_i = 1'b1;
    @(negedge clk);
    cache_ready_i = 1;

    // demand only, response three cycles after issue
    clr_obs(); lat_fix = 2;
    dem_active = 1; dem_addr_i = 32'h100;
    run_until_done("dem_only");
    check_eq("dem_only_done", n_dem_done, 1);
    check_eq("dem_only_issue", n_issue, 1);
    check_eq("dem_only_pc", last_pc, 32'h100);
    cycle();

    // priority and starvation relief
    clr_obs(); lat_fix = 0;
    dem_addr_i = 32'h100; pf_addr_i = 32'h240;
    for (int i = 0; i < 12; i++) begin
      dem_active = 1; pf_active = 1;
      cycle();
    end
    check_eq("starve_ngnt", gnt_log.size(), 6);
    for (int i = 0; i < 6 && i < gnt_log.size(); i++)
      check_eq($sformatf("starve_gnt%0d", i), gnt_log[i], (i % 3 == 2));
    dem_active = 0; pf_active = 0;
    run_until_done("starve");
    cycle();

    // promotion: demand to the line already being prefetched
    clr_obs(); lat_fix = 2;
    pf_active = 1; pf_addr_i = 32'h140;
    cycle();
    dem_active = 1; dem_addr_i = 32'h144;
    run_until_done("promote");
    check_eq("promote_dem", n_dem_done, 1);
    check_eq("promote_pf", n_pf_done, 0);
    check_eq("promote_issue", n_issue, 1);
    cycle();

    // no promotion: different line
    clr_obs();
    pf_active = 1; pf_addr_i = 32'h140;
    cycle();
    dem_active = 1; dem_addr_i = 32'h200;
    run_until_done("nopromo");
    check_eq("nopromo_pf", n_pf_done, 1);
    check_eq("nopromo_dem", n_dem_done, 1);
    check_eq("nopromo_issue", n_issue, 2);
    check_eq("nopromo_pc", last_pc, 32'h200);
    cycle();

    // flush while the demand read is outstanding
    clr_obs(); lat_fix = 2;
    dem_active = 1; dem_addr_i = 32'h100;
    cycle();
    flush_i = 1; cycle(); flush_i = 0;
    run_until_done("flush");
    check_eq("flush_dem", n_dem_done, 0);
    check_eq("flush_issue", n_issue, 1);
    cycle();

    // randomized traffic
    lat_fix = -1;
    for (int i = 0; i < 3000; i++) begin
      if (!dem_active && $urandom % 3 == 0) begin dem_active = 1; dem_addr_i = pick_addr(); end
      if (!pf_active && $urandom % 4 == 0) begin pf_active = 1; pf_addr_i = pick_addr(); end
      cache_ready_i = ($urandom % 4) != 0;
      flush_i = ($urandom % 25) == 0;
      cycle();
    end
    dem_active = 0; pf_active = 0;
    run_until_done("random");
    cycle();

    // asynchronous reset while a prefetch is in flight, then a late response
    lat_fix = 3;
    pf_active = 1; pf_addr_i = 32'h140;
    cycle();
    cycle();
    dem_req_i = 0; pf_req_i = 0; flush_i = 0; cache_done_i = 0; cache_out_i = '0;
    #2 rst_n_i = 1'b0;
    #1 check_outputs_zero("midreset");
    @(negedge clk);
    rst_n_i = 1'b1;
    model_clear();
    clr_obs();
    e_pend = 1; e_cd = 0; e_addr = 32'h140;
    cycle();
    check_eq("late_done_dem", n_dem_done, 0);
    check_eq("late_done_pf", n_pf_done, 0);

    // three demand reads and one promotion after reset
    lat_fix = 1;
    for (int i = 0; i < 3; i++) begin
      dem_active = 1; dem_addr_i = 32'h100 + 32'(i * 'h40);
      run_until_done("perf_dem");
      cycle();
    end
    pf_active = 1; pf_addr_i = 32'h240;
    cycle();
    dem_active = 1; dem_addr_i = 32'h248;
    run_until_done("perf_promote");
    cycle();
    check_eq("perf_seq_dem", n_dem_done, 4);
    check_eq("perf_seq_pf", n_pf_done, 0);
`ifdef ICARB_PERF_CNT_EN
    check_eq("cnt_dem", cnt_dem_o, 4);
    check_eq("cnt_pf", cnt_pf_o, 1);
    check_eq("cnt_promote", cnt_promote_o, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
